// File: rtl/piso_tx.sv
// piso_tx: parallel-in, serial-out transmitter.
// Words go out MSB first at one bit per cycle. A one-word hold register
// lets the next word queue up while the current one shifts, so a
// continuously valid source streams with no idle gap between words.
module piso_tx #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             serial_out,
  output logic             frame_start,
  output logic             done,
  output logic             busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hold;
  logic             r_holdValid;

  logic w_accept;
  logic w_lastBit;

  // Handshake completes when the source offers a word and the hold slot is free
  always_comb begin
    w_accept  = data_valid && !r_holdValid;
    w_lastBit = (r_cnt == LAST_BIT);
  end

  // Transmit state machine: loads the shifter, queues a word in the hold
  // register mid-frame, and chains frames back to back at the LSB boundary
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_hold      <= '0;
      r_holdValid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shift <= data_in;
            r_cnt   <= '0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (!w_lastBit) begin
            r_shift <= {r_shift[WIDTH-2:0], 1'b0};
            r_cnt   <= r_cnt + CW'(1);
            if (w_accept) begin
              r_hold      <= data_in;
              r_holdValid <= 1'b1;
            end
          end else if (r_holdValid) begin
            r_shift     <= r_hold;
            r_holdValid <= 1'b0;
            r_cnt       <= '0;
          end else if (w_accept) begin
            r_shift <= data_in;
            r_cnt   <= '0;
          end else begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_shift <= '0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Outputs are pure decodes of registered state; the shifter is zero in IDLE
  always_comb begin
    data_ready  = !r_holdValid;
    serial_out  = r_shift[WIDTH-1];
    busy        = (r_state == SHIFT);
    frame_start = (r_state == SHIFT) && (r_cnt == '0);
    done        = (r_state == SHIFT) && w_lastBit;
  end

endmodule
